// File: rtl/aes_pkg.sv
// Shared AES definitions: front-end FSM states, word/block geometry and the
// key-expansion round constants.
package aes_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BLK_WORDS = 4;
  localparam int unsigned BLK_W     = WORD_W * BLK_WORDS;

  typedef enum logic [1:0] {
    S_LOAD,
    S_WAIT,
    S_EMIT
  } state_e;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] aes_rcon(input int unsigned round);
    return RCON[round];
  endfunction

endpackage

// File: rtl/aes_word_serializer.sv
// Holds the captured cipher result and streams it out as four 32-bit words,
// most significant word first, over a valid/ready handshake.
module aes_word_serializer
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [BLK_W-1:0]  data_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [WORD_W-1:0] out_data_o,
  output logic              done_o
);

  logic [BLK_W-1:0]  res_q;
  logic [1:0]        out_cnt_q;
  logic              valid_q;
  logic              fire;
  logic              last;
  logic [WORD_W-1:0] word;

  assign fire   = valid_q && out_ready_i;
  assign last   = (out_cnt_q == 2'(BLK_WORDS - 1));
  assign done_o = fire && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q     <= '0;
      out_cnt_q <= '0;
      valid_q   <= 1'b0;
    end else if (load_i) begin
      res_q     <= data_i;
      out_cnt_q <= '0;
      valid_q   <= 1'b1;
    end else if (fire) begin
      out_cnt_q <= out_cnt_q + 2'd1;
      if (last) valid_q <= 1'b0;
    end
  end

  always_comb begin
    word = '0;
    case (out_cnt_q)
      2'd0:    word = res_q[127:96];
      2'd1:    word = res_q[95:64];
      2'd2:    word = res_q[63:32];
      default: word = res_q[31:0];
    endcase
  end

  // Index holds during a stall, so the word stays stable until accepted.
  assign out_valid_o = valid_q;
  assign out_data_o  = valid_q ? word : '0;

endmodule

// File: rtl/aes_stream_frontend.sv
// Word-stream front end for the combinational AES stage: loads key and
// plaintext words, holds the block for CIPHER_LAT cycles, then streams the result.
module aes_stream_frontend
  import aes_pkg::*;
#(
  parameter int unsigned NK         = 4,
  parameter int unsigned CIPHER_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_wr,
  input  logic [WORD_W-1:0]    key_word,
  output logic                 key_drop,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_data,
  output logic [BLK_W-1:0]     cipher_in,
  output logic [NK*WORD_W-1:0] cipher_key,
  input  logic [BLK_W-1:0]     cipher_out,
  output logic                 busy
);

  localparam int unsigned KEY_W = NK * WORD_W;
  localparam int unsigned KCW   = $clog2(NK);

  state_e            state_q, state_d;
  logic [KEY_W-1:0]  key_reg_q, key_reg_d;
  logic [KCW-1:0]    key_cnt_q, key_cnt_d;
  logic              key_ok_q, key_ok_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [1:0]        word_cnt_q, word_cnt_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              key_drop_q, key_drop_d;
  logic              in_fire;
  logic              ser_load;
  logic              ser_done;

  // Key writes win over plaintext in the same cycle.
  assign in_ready = (state_q == S_LOAD) && key_ok_q && !key_wr;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LOAD;
      key_reg_q  <= '0;
      key_cnt_q  <= '0;
      key_ok_q   <= 1'b0;
      blk_q      <= '0;
      word_cnt_q <= '0;
      wait_cnt_q <= '0;
      key_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_reg_q  <= key_reg_d;
      key_cnt_q  <= key_cnt_d;
      key_ok_q   <= key_ok_d;
      blk_q      <= blk_d;
      word_cnt_q <= word_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      key_drop_q <= key_drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    key_reg_d  = key_reg_q;
    key_cnt_d  = key_cnt_q;
    key_ok_d   = key_ok_q;
    blk_d      = blk_q;
    word_cnt_d = word_cnt_q;
    wait_cnt_d = wait_cnt_q;
    key_drop_d = 1'b0;
    ser_load   = 1'b0;

    if (key_wr) begin
      if (state_q == S_LOAD) begin
        key_reg_d = {key_reg_q[KEY_W-WORD_W-1:0], key_word};
        if (key_cnt_q == KCW'(NK - 1)) begin
          key_cnt_d = '0;
          key_ok_d  = 1'b1;
        end else begin
          key_cnt_d = key_cnt_q + 1'b1;
        end
      end else begin
        key_drop_d = 1'b1;
      end
    end

    case (state_q)
      S_LOAD: begin
        if (in_fire) begin
          blk_d      = {blk_q[BLK_W-WORD_W-1:0], in_data};
          word_cnt_d = word_cnt_q + 2'd1;
          if (word_cnt_q == 2'(BLK_WORDS - 1)) begin
            state_d    = S_WAIT;
            wait_cnt_d = 4'(CIPHER_LAT - 1);
          end
        end
      end
      S_WAIT: begin
        // Block has been stable CIPHER_LAT cycles when the count reaches zero.
        if (wait_cnt_q == 4'd0) begin
          ser_load = 1'b1;
          state_d  = S_EMIT;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      S_EMIT: begin
        if (ser_done) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  aes_word_serializer u_ser (
    .clk         (clk),
    .rst         (rst),
    .load_i      (ser_load),
    .data_i      (cipher_out),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .done_o      (ser_done)
  );

  assign cipher_in  = blk_q;
  assign cipher_key = key_reg_q;
  assign key_drop   = key_drop_q;
  assign busy       = (state_q != S_LOAD);

endmodule

// File: tb/tb_aes_stream_frontend.sv
// Self-checking bench for aes_stream_frontend with a stand-in multicycle cipher.
module tb_aes_stream_frontend;

  localparam int LAT = 3;

  localparam logic [127:0] APPB_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] APPB_PT  = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] APPB_CT  = 128'h3925841d_02dc09fb_dc118597_196a0b32;
  localparam logic [127:0] C1_KEY   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] C1_PT    = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] C1_CT    = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_wr = 1'b0;
  logic [31:0]  key_word = '0;
  logic         key_drop;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic [127:0] cipher_in;
  logic [127:0] cipher_key;
  logic [127:0] cipher_out;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_hs = 0;
  logic [127:0] model_key = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_stream_frontend #(
    .NK         (4),
    .CIPHER_LAT (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_wr     (key_wr),
    .key_word   (key_word),
    .key_drop   (key_drop),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .cipher_in  (cipher_in),
    .cipher_key (cipher_key),
    .cipher_out (cipher_out),
    .busy       (busy)
  );

  // Stand-in cipher: known FIPS-197 vectors, otherwise an arbitrary keyed mix.
  function automatic logic [127:0] cipher_ref(input logic [127:0] pt, input logic [127:0] key);
    if (pt == APPB_PT && key == APPB_KEY) return APPB_CT;
    if (pt == C1_PT && key == C1_KEY) return C1_CT;
    return {pt[63:0], pt[127:64]} ^ {key[95:0], key[127:96]} ^ 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  endfunction

  // Output is only correct after the inputs have been stable LAT cycles.
  int           age = 0;
  logic [127:0] prev_in = '0;
  logic [127:0] prev_key = '0;
  always @(negedge clk) begin
    if (cipher_in !== prev_in || cipher_key !== prev_key) age <= 1;
    else if (age < 15) age <= age + 1;
    prev_in  <= cipher_in;
    prev_key <= cipher_key;
  end
  assign cipher_out = (age >= LAT) ? cipher_ref(cipher_in, cipher_key)
                                   : ~cipher_ref(cipher_in, cipher_key);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    for (int i = 0; i < 4; i++) begin
      key_wr   = 1'b1;
      key_word = k[127-32*i -: 32];
      @(posedge clk); #1;
    end
    key_wr    = 1'b0;
    model_key = k;
  endtask

  task automatic send_word(input logic [31:0] w);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
      if (done) last_hs = cyc;
    end
    in_valid = 1'b0;
    if (!done) check("in_ready_timeout", 128'(done), 128'(1));
  endtask

  task automatic send_block(input logic [127:0] pt);
    for (int i = 0; i < 4; i++) send_word(pt[127-32*i -: 32]);
  endtask

  task automatic recv_block(input logic [127:0] exp, input bit rnd, input bit chk_lat,
                            input int t4);
    int          got = 0;
    bit          stalled = 1'b0;
    bit          first = 1'b1;
    logic [31:0] held = '0;
    for (int n = 0; n < 200 && got < 4; n++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (out_valid) begin
        if (first && chk_lat) check("first_valid_lat", 128'(cyc - t4), 128'(LAT));
        first = 1'b0;
        if (stalled) check("stall_stable", 128'(out_data), 128'(held));
        if (out_ready) begin
          check($sformatf("out_word%0d", got), 128'(out_data), 128'(exp[127-32*got -: 32]));
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = out_data;
        end
      end
      @(posedge clk); #1;
    end
    if (got < 4) check("recv_timeout", 128'(got), 128'(4));
    out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"}, 128'({in_ready, out_valid, key_drop, busy}), 128'(0));
    check({tag, "_out_data"}, 128'(out_data), 128'(0));
    check({tag, "_cipher_in"}, cipher_in, 128'(0));
    check({tag, "_cipher_key"}, cipher_key, 128'(0));
  endtask

  initial begin
    int t4a;
    int t4b;
    logic [127:0] pt;
    logic [127:0] k;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // No key loaded: plaintext must be refused.
    in_valid = 1'b1;
    in_data  = 32'hdead_beef;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("nokey_in_ready", 128'(in_ready), 128'(0));
      check("nokey_out_valid", 128'({out_valid, busy}), 128'(0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // App. B with exact latency, then a back-to-back repeat.
    load_key(APPB_KEY);
    check("appb_cipher_key", cipher_key, APPB_KEY);
    send_block(APPB_PT);
    t4a = last_hs;
    check("appb_cipher_in", cipher_in, APPB_PT);
    @(negedge clk);
    check("appb_busy", 128'({busy, in_ready}), 128'(2'b10));
    @(posedge clk); #1;
    recv_block(APPB_CT, 1'b0, 1'b1, t4a);
    send_block(APPB_PT);
    t4b = last_hs;
    check("b2b_period", 128'(t4b - t4a), 128'(8 + LAT));
    recv_block(APPB_CT, 1'b0, 1'b1, t4b);

    // App. C.1 with random backpressure.
    load_key(C1_KEY);
    send_block(C1_PT);
    recv_block(C1_CT, 1'b1, 1'b0, last_hs);

    // Key write during emit is dropped.
    pt = {$urandom, $urandom, $urandom, $urandom};
    send_block(pt);
    for (int n = 0; n < 20 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    check("emit_reached", 128'(out_valid), 128'(1));
    key_wr   = 1'b1;
    key_word = $urandom;
    @(negedge clk);
    check("key_drop_pre", 128'(key_drop), 128'(0));
    @(posedge clk); #1;
    key_wr = 1'b0;
    @(negedge clk);
    check("key_drop_pulse", 128'(key_drop), 128'(1));
    check("key_kept", cipher_key, model_key);
    @(posedge clk); #1;
    @(negedge clk);
    check("key_drop_end", 128'(key_drop), 128'(0));
    @(posedge clk); #1;
    recv_block(cipher_ref(pt, model_key), 1'b1, 1'b0, 0);

    // Random keys and blocks.
    for (int b = 0; b < 4; b++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      load_key(k);
      send_block(pt);
      recv_block(cipher_ref(pt, k), 1'b1, 1'b0, 0);
    end

    // Reset mid-block clears everything including the key.
    load_key(APPB_KEY);
    send_word(APPB_PT[127:96]);
    send_word(APPB_PT[95:64]);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("midrst_no_key", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    load_key(APPB_KEY);
    send_block(APPB_PT);
    recv_block(APPB_CT, 1'b0, 1'b1, last_hs);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_stream_frontend.md
# aes_stream_frontend

Sequential word-stream front end for the combinational AES cipher stage. It loads a cipher key and 128-bit plaintext blocks as 32-bit words over valid/ready handshakes, and presents the assembled block and key to the cipher. After a fixed settle time it captures the 128-bit result and streams it back out as four 32-bit words. It sits directly upstream and downstream of the cipher and is the only sequential logic around it.

## Interface
- NK, 4, key length in 32-bit words (4/6/8); sets `cipher_key` width.
- CIPHER_LAT, 1, cycles the assembled block is held before `cipher_out` is sampled (1..15); covers the multicycle path through the combinational cipher.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_wr  in  1  key word strobe.
- key_word  in  32  key word; first word = key MSW.
- key_drop  out  1  one-cycle pulse: `key_wr` arrived outside S_LOAD and was discarded.
- in_valid  in  1  plaintext word valid.
- in_ready  out  1  plaintext word accepted when high with `in_valid`.
- in_data  in  32  plaintext word; first word = bits [127:96].
- out_valid  out  1  ciphertext word valid.
- out_ready  in  1  consumer accepts word.
- out_data  out  32  ciphertext word; first word = bits [127:96].
- cipher_in  out  128  registered assembled block to the cipher.
- cipher_key  out  NK*32  registered key to the cipher.
- cipher_out  in  128  cipher result.
- busy  out  1  high in S_WAIT and S_EMIT.

## Operation
- States: S_LOAD, S_WAIT, S_EMIT. Reset state is S_LOAD.
- Key loading:
  - Key writes are accepted only in S_LOAD.
  - Each write shifts left: key_reg <= {key_reg[NK*32-33:0], key_word}.
  - key_cnt counts writes modulo NK. `key_ok` sets when key_cnt wraps from NK-1 and stays set until reset.
  - A new key write sequence overwrites the key word by word. `key_ok` stays high during the overwrite, so software must not interleave a key reload with a block.
- Plaintext:
  - in_ready = (state == S_LOAD) && key_ok && !key_wr. Key writes take priority and stall plaintext in the same cycle.
  - Each handshake shifts `in_data` into blk_reg and increments word_cnt (2 bits).
  - On the 4th handshake (word_cnt == 3), word_cnt wraps to 0, the FSM enters S_WAIT, and wait_cnt loads CIPHER_LAT-1.
- S_WAIT:
  - wait_cnt decrements each cycle.
  - When wait_cnt == 0: res_reg <= cipher_out, the FSM enters S_EMIT, out_cnt <= 0.
- S_EMIT:
  - out_data = res_reg[127-32*out_cnt -: 32]. out_valid = 1.
  - On each out_valid && out_ready handshake, out_cnt increments.
  - On the 4th handshake the FSM returns to S_LOAD.
  - out_data is stable while out_valid && !out_ready.
- `cipher_in` = blk_reg and `cipher_key` = key_reg. Both are direct register outputs, with no logic after the flop.
- Reset mid-operation: all state is cleared and any partial block or result is lost. `key_ok` is also cleared, so the key must be reloaded.
- Reset values:
  - in_ready 0, out_valid 0, out_data 0, key_drop 0, busy 0.
  - cipher_in 0, cipher_key 0, and all counters 0.

## Timing
- Input: one word per cycle maximum. The 4th plaintext handshake at cycle t gives S_WAIT from t+1.
- Result: `cipher_out` is sampled at the end of cycle t+CIPHER_LAT. The first out_valid is at t+CIPHER_LAT+1.
- Output: with out_ready held high, 4 words are emitted in 4 consecutive cycles. in_ready reasserts the cycle after the last output handshake.
- Peak throughput: one block per 8+CIPHER_LAT cycles. There is no overlap of load and emit.
- key_drop is asserted in the cycle after the dropped key_wr.

## Structure
- Shared package `aes_pkg`:
  - state enum {S_LOAD, S_WAIT, S_EMIT};
  - WORD_W = 32;
  - BLK_WORDS = 4;
  - the Rcon constant table, moved here so the key-expansion path and this block share one definition.
- Natural sub-module: `aes_word_serializer`. It holds the 128-bit result register, the out_cnt counter and the out_valid/out_ready logic, driven by a load strobe from the FSM.

## Test plan
- FIPS-197 App. B:
  - stimulus: load key 2b7e1516 28aed2a6 abf71588 09cf4f3c, then plaintext 3243f6a8 885a308d 313198a2 e0370734;
  - required response: out words 3925841d 02dc09fb dc118597 196a0b32, with first out_valid exactly CIPHER_LAT+1 cycles after the 4th input handshake.
- FIPS-197 App. C.1:
  - stimulus: key 00010203…0c0d0e0f, plaintext 00112233…ccddeeff, with out_ready toggled randomly;
  - required response: 69c4e0d8 6a7b0430 d8cdb780 70b4c55a in order, and out_data stable whenever stalled.
- No key loaded: assert in_valid for 10 cycles -> in_ready stays 0 and no output.
- key_wr during S_EMIT -> key_drop pulses for 1 cycle, and key_reg and the output words are unchanged.
- Back-to-back blocks with out_ready=1 and CIPHER_LAT=3 -> each block takes exactly 11 cycles; check the second App. B block yields the same ciphertext.
- Assert rst after 2 plaintext words:
  - all outputs return to reset values and in_ready is 0;
  - after key reload, a full block produces the correct App. B ciphertext.
